// File: rtl/reset_trim_pkg.sv
// reset_trim_pkg: shared states, cause codes and default boot vector for reset_trim_seq
package reset_trim_pkg;

    typedef enum logic [1:0] {
        ASSERT = 2'd0,
        STAGE  = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_EXT = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;
    localparam logic [1:0] CAUSE_WDT = 2'b11;

    localparam logic [31:0] DEFAULT_VEC_C = 32'h6000_0000;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reset_stage_cnt.sv
// reset_stage_cnt: terminal counter that pulses done on the cycle it reaches MAX-1, then wraps
module reset_stage_cnt
    import reset_trim_pkg::*;
#(
    parameter int MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic done
);

    localparam int W = cnt_w(MAX);

    logic [W-1:0] cnt;

    assign done = en && (cnt == W'(MAX - 1));

    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt <= '0;
        else if (en)
            cnt <= done ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/reset_trim_seq.sv
// reset_trim_seq: staged multi-domain reset sequencer with latched boot vector.
// Define RESET_WDT_EN to build the RUN-state watchdog.
module reset_trim_seq
    import reset_trim_pkg::*;
#(
    parameter int                NUM_DOMAINS = 4,
    parameter int                STRETCH     = 16,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] DEFAULT_VEC = ADDR_W'(DEFAULT_VEC_C),
    parameter int                WDT_CYCLES  = 65536
) (
    input  logic                   clk12,
    input  logic                   reset,
    input  logic                   sw_reset_req,
    input  logic                   wdt_kick,
    input  logic [ADDR_W-1:0]      trimming_reset,
    input  logic                   trimming_reset_ena,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic [ADDR_W-1:0]      reset_vector,
    output logic                   seq_busy,
    output logic [1:0]             reset_cause
);

    localparam int                IW       = cnt_w(NUM_DOMAINS);
    localparam logic [ADDR_W-1:0] VEC_MASK = ~ADDR_W'(3);

    state_t        state, state_n;
    logic [1:0]    cause_n;
    logic [IW-1:0] idx;
    logic          stage_done, last, wdt_done;

    reset_stage_cnt #(.MAX(STRETCH)) u_stage (
        .clk  (clk12),
        .rst  (reset),
        .clear(state != STAGE),
        .en   (state == STAGE),
        .done (stage_done)
    );

`ifdef RESET_WDT_EN
    reset_stage_cnt #(.MAX(WDT_CYCLES)) u_wdt (
        .clk  (clk12),
        .rst  (reset),
        .clear(state != RUN || wdt_kick),
        .en   (state == RUN),
        .done (wdt_done)
    );
`else
    localparam int unused_wdt_cycles = WDT_CYCLES;
    logic unused_kick;
    assign unused_kick = wdt_kick;
    assign wdt_done    = 1'b0;
`endif

    assign last     = stage_done && (idx == IW'(NUM_DOMAINS - 1));
    assign seq_busy = (state != RUN);

    always_comb begin
        state_n = state;
        cause_n = reset_cause;
        if (state == ASSERT)
            state_n = STAGE;
        else if (state == STAGE)
            state_n = last ? RUN : STAGE;
        else if (sw_reset_req || wdt_done) begin
            state_n = ASSERT;
            cause_n = sw_reset_req ? CAUSE_SW : CAUSE_WDT;
        end
    end

    always_ff @(posedge clk12) begin
        if (reset) begin
            state        <= ASSERT;
            idx          <= '0;
            domain_reset <= '1;
            reset_cause  <= CAUSE_EXT;
            reset_vector <= DEFAULT_VEC & VEC_MASK;
        end else begin
            state       <= state_n;
            reset_cause <= cause_n;
            if (state == ASSERT)
                reset_vector <= (trimming_reset_ena ? trimming_reset : DEFAULT_VEC) & VEC_MASK;
            if (state_n == ASSERT) begin
                domain_reset <= '1;
                idx          <= '0;
            end else if (stage_done) begin
                domain_reset[idx] <= 1'b0;
                idx               <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reset_trim_seq.sv
// tb_reset_trim_seq: directed self-checking bench for reset_trim_seq (STRETCH=16, 4 domains)
module tb_reset_trim_seq;

    logic        clk12 = 1'b0;
    logic        reset = 1'b1;
    logic        sw_reset_req = 1'b0;
    logic        wdt_kick = 1'b0;
    logic [31:0] trimming_reset = 32'h0;
    logic        trimming_reset_ena = 1'b0;
    logic [3:0]  domain_reset;
    logic [31:0] reset_vector;
    logic        seq_busy;
    logic [1:0]  reset_cause;

    int vectors = 0;
    int errors  = 0;

    reset_trim_seq #(
        .NUM_DOMAINS(4),
        .STRETCH    (16),
        .ADDR_W     (32),
        .DEFAULT_VEC(32'h6000_0000),
        .WDT_CYCLES (100)
    ) dut (
        .clk12             (clk12),
        .reset             (reset),
        .sw_reset_req      (sw_reset_req),
        .wdt_kick          (wdt_kick),
        .trimming_reset    (trimming_reset),
        .trimming_reset_ena(trimming_reset_ena),
        .domain_reset      (domain_reset),
        .reset_vector      (reset_vector),
        .seq_busy          (seq_busy),
        .reset_cause       (reset_cause)
    );

    always #5 clk12 = ~clk12;

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk12);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        trimming_reset     = 32'h6000_0002;
        trimming_reset_ena = 1'b1;
        ticks(10);
        chk("rst_dom",   32'(domain_reset), 32'hF);
        chk("rst_busy",  32'(seq_busy),     32'h1);
        chk("rst_cause", 32'(reset_cause),  32'h1);
        chk("rst_vec",   reset_vector,      32'h6000_0000);

        reset = 1'b0;
        ticks(1);
        chk("e0_vec", reset_vector,      32'h6000_0000);
        chk("e0_dom", 32'(domain_reset), 32'hF);
        ticks(15);
        chk("e15_dom", 32'(domain_reset), 32'hF);
        ticks(1);
        chk("e16_dom", 32'(domain_reset), 32'hE);
        ticks(15);
        chk("e31_dom", 32'(domain_reset), 32'hE);
        ticks(1);
        chk("e32_dom", 32'(domain_reset), 32'hC);
        ticks(16);
        chk("e48_dom", 32'(domain_reset), 32'h8);
        ticks(15);
        chk("e63_busy", 32'(seq_busy), 32'h1);
        ticks(1);
        chk("e64_dom",   32'(domain_reset), 32'h0);
        chk("e64_busy",  32'(seq_busy),     32'h0);
        chk("e64_cause", 32'(reset_cause),  32'h1);

        trimming_reset = 32'h1234_5678;
        ticks(5);
        chk("run_vec_stable", reset_vector, 32'h6000_0000);

        trimming_reset = 32'h1234_567B;
        sw_reset_req   = 1'b1;
        ticks(1);
        sw_reset_req = 1'b0;
        chk("sw_dom",   32'(domain_reset), 32'hF);
        chk("sw_cause", 32'(reset_cause),  32'h2);
        chk("sw_busy",  32'(seq_busy),     32'h1);
        ticks(1);
        chk("sw_vec", reset_vector,      32'h1234_5678);
        chk("sw_latch_dom", 32'(domain_reset), 32'hF);
        ticks(15);
        chk("sw_pre_rel", 32'(domain_reset), 32'hF);
        ticks(1);
        chk("sw_rel0", 32'(domain_reset), 32'hE);
        sw_reset_req = 1'b1;
        ticks(1);
        sw_reset_req = 1'b0;
        chk("sw_stage_ignored", 32'(domain_reset), 32'hE);
        ticks(14);
        chk("sw_pre_rel1", 32'(domain_reset), 32'hE);
        ticks(1);
        chk("sw_rel1", 32'(domain_reset), 32'hC);
        ticks(32);
        chk("sw_run_dom",   32'(domain_reset), 32'h0);
        chk("sw_run_busy",  32'(seq_busy),     32'h0);
        chk("sw_run_cause", 32'(reset_cause),  32'h2);

        trimming_reset_ena = 1'b0;
        sw_reset_req       = 1'b1;
        ticks(1);
        sw_reset_req = 1'b0;
        ticks(1);
        chk("ena0_vec", reset_vector, 32'h6000_0000);
        trimming_reset_ena = 1'b1;
        ticks(39);
        chk("mid_e39_dom", 32'(domain_reset), 32'hC);
        reset = 1'b1;
        ticks(1);
        chk("mid_rst_dom",   32'(domain_reset), 32'hF);
        chk("mid_rst_cause", 32'(reset_cause),  32'h1);
        chk("mid_rst_busy",  32'(seq_busy),     32'h1);
        reset = 1'b0;
        ticks(16);
        chk("mid_e15_dom", 32'(domain_reset), 32'hF);
        ticks(1);
        chk("mid_e16_dom", 32'(domain_reset), 32'hE);
        chk("mid_vec",     reset_vector,      32'h1234_5678);
        ticks(48);
        chk("mid_run_dom",  32'(domain_reset), 32'h0);
        chk("mid_run_busy", 32'(seq_busy),     32'h0);

`ifdef RESET_WDT_EN
        ticks(99);
        chk("wdt_pre_dom", 32'(domain_reset), 32'h0);
        ticks(1);
        chk("wdt_dom",   32'(domain_reset), 32'hF);
        chk("wdt_cause", 32'(reset_cause),  32'h3);
        ticks(65);
        chk("wdt_rerun_dom", 32'(domain_reset), 32'h0);
        for (int i = 0; i < 4; i++) begin
            ticks(49);
            wdt_kick = 1'b1;
            ticks(1);
            wdt_kick = 1'b0;
        end
        chk("wdt_kick_dom",   32'(domain_reset), 32'h0);
        chk("wdt_kick_cause", 32'(reset_cause),  32'h3);
`else
        ticks(200);
        chk("nowdt_dom",   32'(domain_reset), 32'h0);
        chk("nowdt_cause", 32'(reset_cause),  32'h1);
        chk("nowdt_busy",  32'(seq_busy),     32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/reset_trim_seq.md
# reset_trim_seq

Parametrised reset sequencer for the cram_soc top, clocked by the main 12 MHz domain. It stretches the board reset, releases `NUM_DOMAINS` reset outputs in a staged order, and latches a word-aligned boot vector from the trimming inputs. It also supports software-requested re-sequencing and, optionally, a watchdog. It replaces the single trimming-reset path with a multi-domain, multi-cause sequencer.

## Interface
- `NUM_DOMAINS`, 4: number of staged reset outputs, 1..8.
- `STRETCH`, 16: cycles between successive releases, >=1.
- `ADDR_W`, 32: boot vector width.
- `DEFAULT_VEC`, 32'h6000_0000: vector used when trimming is disabled.
- `WDT_CYCLES`, 65536: watchdog timeout; used only with `RESET_WDT_EN`.
- `clk12`  in  1: sole clock.
- `reset`  in  1: synchronous, active-high external reset request.
- `sw_reset_req`  in  1: single-cycle software reset request.
- `wdt_kick`  in  1: watchdog service pulse.
- `trimming_reset`  in  ADDR_W: requested boot vector.
- `trimming_reset_ena`  in  1: selects `trimming_reset` over `DEFAULT_VEC`.
- `domain_reset`  out  NUM_DOMAINS: active-high reset per domain; bit 0 releases first.
- `reset_vector`  out  ADDR_W: latched boot vector; low 2 bits are always 0.
- `seq_busy`  out  1: high whenever the state is not RUN.
- `reset_cause`  out  2: cause of the last sequence. 01 = external, 10 = software, 11 = watchdog.

## Operation
- States:
  - ASSERT: all domains held in reset.
  - STAGE: counts `STRETCH` cycles between releases and holds the domain index `idx`.
  - RUN: all domains released.
- Reset values, forced on any edge that samples `reset`=1:
  - state = ASSERT, counter = 0, `idx` = 0.
  - `domain_reset` = all 1s, `seq_busy` = 1.
  - `reset_cause` = 01.
  - `reset_vector` = `DEFAULT_VEC` with the low 2 bits cleared.
- Transitions:
  - ASSERT -> STAGE on the first edge with `reset`=0. On this edge the vector is latched: `ena` ? `trimming_reset` : `DEFAULT_VEC`, with bits [1:0] forced to 0.
  - In STAGE the counter increments each cycle. When it reaches `STRETCH`-1, `domain_reset[idx]` clears, the counter resets, and `idx` increments.
  - When the release of `idx`=`NUM_DOMAINS`-1 occurs, the next state is RUN.
  - RUN with `sw_reset_req`=1 -> ASSERT for exactly one cycle with `reset_cause` = 10; the sequence then restarts and re-latches the vector.
- `sw_reset_req` is ignored in ASSERT and STAGE.
- `reset` wins over `sw_reset_req` and the watchdog when they occur in the same cycle.
- `reset` asserted mid-sequence re-asserts all domains on the next edge; released domains are not preserved.
- The vector is latched only at the ASSERT->STAGE edge. Changes to `trimming_reset` or `ena` at any other time have no effect.
- Released domains stay released until the next ASSERT. Domains are never released out of order.

## Timing
- Cycle 0 is the first edge sampling `reset`=0.
- `domain_reset[k]` falls at edge `(k+1)*STRETCH`. It is registered, so it is visible in the cycle after that edge.
- `seq_busy` falls at the same edge as `domain_reset[NUM_DOMAINS-1]`.
- Software reset: `domain_reset` goes to all 1s one edge after `sw_reset_req` is sampled. Domain 0 releases `STRETCH` edges after the single ASSERT cycle.
- Counter width is `$clog2(STRETCH)` with a minimum of 1. `STRETCH`=1 releases one domain per cycle.
- `reset_vector` is stable from the latch edge onward; consumers may sample it once `domain_reset[0]`=0.

## Configuration
- `RESET_WDT_EN` defined:
  - A counter runs only in RUN and clears on `wdt_kick`.
  - Reaching `WDT_CYCLES`-1 without a kick enters ASSERT with `reset_cause` = 11; the sequence proceeds as for a software reset.
  - The counter is held at 0 outside RUN.
- `RESET_WDT_EN` undefined:
  - No watchdog logic is built.
  - `wdt_kick` is ignored and `reset_cause` is never 11.
  - The port list is unchanged.

## Structure
- Package `reset_trim_pkg` holds:
  - the state enum (ASSERT, STAGE, RUN);
  - the cause constants (CAUSE_EXT=2'b01, CAUSE_SW=2'b10, CAUSE_WDT=2'b11);
  - the default vector constant.
- One sub-module, `reset_stage_cnt`: a parametrised terminal counter with `clear`/`en` inputs and a `done` output. It is instantiated for the stage counter and, under `RESET_WDT_EN`, for the watchdog.

## Test plan
- Power-on: `reset` high for 10 cycles, then low, with `STRETCH`=16 and `NUM_DOMAINS`=4 -> domains release at edges 16/32/48/64; `seq_busy` falls at edge 64; cause = 01.
- Trim vector: `trimming_reset`=32'h6000_0002 with `ena`=1 at the release edge -> `reset_vector`=32'h6000_0000. With `ena`=0 -> `DEFAULT_VEC`.
- Vector stability: change `trimming_reset` to 32'h1234_5678 in RUN -> `reset_vector` is unchanged.
- Mid-sequence reset: assert `reset` at edge 40, after domains 0-1 have released -> all domains return to 1 on the next edge, and the full sequence restarts after release.
- Software reset: `sw_reset_req` pulse in RUN -> all 1s for one cycle, then staged release; cause = 10. A pulse during STAGE -> no effect.
- Watchdog (with `RESET_WDT_EN`, `WDT_CYCLES`=100): no kick for 100 cycles in RUN -> resequence with cause = 11. A kick every 50 cycles -> no reset.
